// File: rtl/top_test.sv
// top_test: single-layer CNN engine. Four MAC PEs (one per output filter) convolve
// an input image held in a single-port on-chip byte memory. Optional ReLU and
// optional 2x2 max-pooling; results are written back to the same memory.
// Build option: define MAXPOOL_EN to include the POOL phase; without it the
// maxpooling_or_not input is ignored and mp_picture_finish stays low.
module top_test #(
  parameter int WIDTH      = 8,
  parameter int DECIMAL    = 4,
  parameter int MEMADDRBIT = 17,
  parameter int DI         = 1,
  parameter int DR         = 8,
  parameter int DC         = 8,
  parameter int DK         = 3,
  parameter int WBASE      = 1024,
  parameter int OBASE      = 2048,
  parameter int PBASE      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnn_start,
  input  logic                  relu,
  input  logic                  maxpooling_or_not,
  input  logic                  checkbram,
  input  logic                  host_we,
  input  logic [WIDTH-1:0]      host_wdata,
  input  logic [MEMADDRBIT-1:0] memaddr_check,
  output logic [MEMADDRBIT-1:0] memaddr,
  output logic [WIDTH-1:0]      mem_in,
  output logic [WIDTH-1:0]      mem_out,
  output logic                  wea_w,
  output logic [7:0]            cnn_state,
  output logic                  cnn_finish,
  output logic                  filter_finish,
  output logic                  picture_finish,
  output logic                  mp_picture_finish
);

  localparam int DO  = 4;
  localparam int DRO = DR - DK + 1;
  localparam int DCO = DC - DK + 1;
  localparam int NT  = DI * DK * DK;
  localparam int NW  = DO * NT;
  localparam int PW  = 2 * WIDTH;
  localparam int AW  = 20;
  localparam int CW  = 16;
  localparam logic signed [AW-1:0] QMAX = AW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] QMIN = ~QMAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADW = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_POOL  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               ii_q, ii_d, kr_q, kr_d, kc_q, kc_d;
  logic [7:0]               r_q, r_d, c_q, c_d;
  logic                     relu_q, relu_d;
  logic signed [WIDTH-1:0]  w_q [NW];
  logic signed [WIDTH-1:0]  w_d [NW];
  logic signed [AW-1:0]     acc_q [DO];
  logic signed [AW-1:0]     acc_d [DO];
  logic signed [WIDTH-1:0]  tw [DO];
  logic signed [WIDTH-1:0]  x;
  logic                     last_pix;
  logic [WIDTH-1:0]         mem [2**MEMADDRBIT];
  logic [WIDTH-1:0]         rdata_q;
  logic                     unused_ok;
`ifdef MAXPOOL_EN
  localparam int DRP = DRO / 2;
  localparam int DCP = DCO / 2;
  logic                     pool_q, pool_d;
  logic [7:0]               o_q, o_d;
  logic signed [WIDTH-1:0]  max_q, max_d;
  assign unused_ok = ^{1'b0, 32'(PBASE)};
`else
  assign unused_ok = ^{maxpooling_or_not, 32'(PBASE)};
`endif

  // Shift out the fraction, saturate to the signed byte range, then optional ReLU.
  function automatic logic [WIDTH-1:0] quantize(input logic signed [AW-1:0] a, input logic rl);
    logic signed [AW-1:0] s;
    logic [WIDTH-1:0]     q;
    s = a >>> DECIMAL;
    if (s > QMAX)      q = QMAX[WIDTH-1:0];
    else if (s < QMIN) q = QMIN[WIDTH-1:0];
    else               q = s[WIDTH-1:0];
    if (rl && q[WIDTH-1]) q = '0;
    return q;
  endfunction

  assign cnn_state = 8'(state_q);
  assign mem_out   = rdata_q;
  assign x         = $signed(rdata_q);
  assign last_pix  = (r_q == 8'(DRO - 1)) && (c_q == 8'(DCO - 1));

  // Single-port byte memory: synchronous write, registered read; never reset.
  always_ff @(posedge clk) begin
    if (wea_w) mem[memaddr] <= mem_in;
    rdata_q <= mem[memaddr];
  end

  // Next-state, datapath updates and memory port drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ii_d    = ii_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    r_d     = r_q;
    c_d     = c_q;
    relu_d  = relu_q;
    w_d     = w_q;
    acc_d   = acc_q;
    tw      = '{default: '0};
`ifdef MAXPOOL_EN
    pool_d  = pool_q;
    o_d     = o_q;
    max_d   = max_q;
`endif
    memaddr           = '0;
    mem_in            = '0;
    wea_w             = 1'b0;
    cnn_finish        = 1'b0;
    filter_finish     = 1'b0;
    picture_finish    = 1'b0;
    mp_picture_finish = 1'b0;
    case (state_q)
      S_IDLE: begin
        memaddr = memaddr_check;
        mem_in  = host_wdata;
        wea_w   = checkbram && host_we;
        if (cnn_start) begin
          state_d = S_LOADW;
          relu_d  = relu;
`ifdef MAXPOOL_EN
          pool_d  = maxpooling_or_not;
          o_d     = '0;
`endif
          cnt_d   = '0;
          ii_d    = '0;
          kr_d    = '0;
          kc_d    = '0;
          r_d     = '0;
          c_d     = '0;
          acc_d   = '{default: '0};
        end
      end
      S_LOADW: begin
        memaddr = MEMADDRBIT'(WBASE + 32'(cnt_q));
        // Read data lags the address by one cycle, so slot k fills when cnt is k+1.
        for (int unsigned k = 0; k < NW; k++)
          if (cnt_q == CW'(k + 1)) w_d[k] = x;
        if (cnt_q == CW'(NW)) begin
          filter_finish = 1'b1;
          state_d       = S_MAC;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MAC: begin
        memaddr = MEMADDRBIT'(32'(ii_q) * DR * DC + (32'(r_q) + 32'(kr_q)) * DC
                              + 32'(c_q) + 32'(kc_q));
        for (int unsigned o = 0; o < DO; o++)
          for (int unsigned t = 0; t < NT; t++)
            if (cnt_q == CW'(t + 1)) tw[o] = w_q[o * NT + t];
        if (cnt_q != '0)
          for (int unsigned o = 0; o < DO; o++)
            acc_d[o] = acc_q[o] + AW'(PW'(x) * PW'(tw[o]));
        // Tap counters wrap back to zero after the last tap, ready for the next pixel.
        if (cnt_q < CW'(NT)) begin
          if (kc_q == 8'(DK - 1)) begin
            kc_d = '0;
            if (kr_q == 8'(DK - 1)) begin
              kr_d = '0;
              ii_d = (ii_q == 8'(DI - 1)) ? '0 : ii_q + 1'b1;
            end else begin
              kr_d = kr_q + 1'b1;
            end
          end else begin
            kc_d = kc_q + 1'b1;
          end
        end
        if (cnt_q == CW'(NT)) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        memaddr = MEMADDRBIT'(OBASE + 32'(cnt_q) * DRO * DCO + 32'(r_q) * DCO + 32'(c_q));
        mem_in  = quantize(acc_q[cnt_q[1:0]], relu_q);
        wea_w   = 1'b1;
        if (cnt_q == CW'(DO - 1)) begin
          cnt_d = '0;
          acc_d = '{default: '0};
          if (c_q == 8'(DCO - 1)) begin
            c_d = '0;
            r_d = (r_q == 8'(DRO - 1)) ? '0 : r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
          if (last_pix) begin
            picture_finish = 1'b1;
`ifdef MAXPOOL_EN
            state_d = pool_q ? S_POOL : S_DONE;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_MAC;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MAXPOOL_EN
      S_POOL: begin
        // cnt 0..3 read the window, 1..4 consume read data, 5 writes the max.
        memaddr = MEMADDRBIT'(OBASE + 32'(o_q) * DRO * DCO
                              + (2 * 32'(r_q) + 32'(cnt_q[1])) * DCO
                              + 2 * 32'(c_q) + 32'(cnt_q[0]));
        if (cnt_q >= CW'(1) && cnt_q <= CW'(4))
          if (cnt_q == CW'(1) || x > max_q) max_d = x;
        if (cnt_q == CW'(5)) begin
          memaddr = MEMADDRBIT'(PBASE + 32'(o_q) * DRP * DCP + 32'(r_q) * DCP + 32'(c_q));
          mem_in  = max_q;
          wea_w   = 1'b1;
          cnt_d   = '0;
          if (c_q == 8'(DCP - 1)) begin
            c_d = '0;
            if (r_q == 8'(DRP - 1)) begin
              r_d = '0;
              if (o_q == 8'(DO - 1)) begin
                o_d               = '0;
                mp_picture_finish = 1'b1;
                state_d           = S_DONE;
              end else begin
                o_d = o_q + 1'b1;
              end
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_DONE: begin
        cnn_finish = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ii_q    <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      relu_q  <= 1'b0;
      for (int unsigned k = 0; k < NW; k++) w_q[k] <= '0;
      for (int unsigned o = 0; o < DO; o++) acc_q[o] <= '0;
`ifdef MAXPOOL_EN
      pool_q  <= 1'b0;
      o_q     <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ii_q    <= ii_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      r_q     <= r_d;
      c_q     <= c_d;
      relu_q  <= relu_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
`ifdef MAXPOOL_EN
      pool_q  <= pool_d;
      o_q     <= o_d;
      max_q   <= max_d;
`endif
    end
  end

endmodule

// File: tb/tb_top_test.sv
// tb_top_test: directed bench for the CNN engine with hand-computed expectations.
module tb_top_test;

  localparam int AB    = 17;
  localparam int WBASE = 1024;
  localparam int OBASE = 2048;
  localparam int PBASE = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cnn_start = 1'b0;
  logic          relu = 1'b0;
  logic          maxpooling_or_not = 1'b0;
  logic          checkbram = 1'b0;
  logic          host_we = 1'b0;
  logic [7:0]    host_wdata = '0;
  logic [AB-1:0] memaddr_check = '0;
  logic [AB-1:0] memaddr;
  logic [7:0]    mem_in, mem_out, cnn_state;
  logic          wea_w, cnn_finish, filter_finish, picture_finish, mp_picture_finish;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  top_test dut (
    .clk(clk), .rst(rst), .cnn_start(cnn_start), .relu(relu),
    .maxpooling_or_not(maxpooling_or_not), .checkbram(checkbram), .host_we(host_we),
    .host_wdata(host_wdata), .memaddr_check(memaddr_check), .memaddr(memaddr),
    .mem_in(mem_in), .mem_out(mem_out), .wea_w(wea_w), .cnn_state(cnn_state),
    .cnn_finish(cnn_finish), .filter_finish(filter_finish),
    .picture_finish(picture_finish), .mp_picture_finish(mp_picture_finish)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input int addr, input logic [7:0] d);
    @(negedge clk);
    checkbram = 1'b1; host_we = 1'b1; memaddr_check = AB'(addr); host_wdata = d;
    @(negedge clk);
    checkbram = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input int addr, output logic [7:0] d);
    @(negedge clk);
    checkbram = 1'b1; host_we = 1'b0; memaddr_check = AB'(addr);
    @(negedge clk);
    d = mem_out;
    checkbram = 1'b0;
  endtask

  // mode 0: every pixel 0x10 (1.0); mode 1: pixel = column index in Q4.4
  task automatic load_inputs(input int mode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        host_write(r * 8 + c, (mode == 0) ? 8'h10 : 8'(c << 4));
  endtask

  // filter 0 gets w0 on every tap, filters 1..3 get w123
  task automatic load_weights(input logic [7:0] w0, input logic [7:0] w123);
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 9; k++)
        host_write(WBASE + o * 9 + k, (o == 0) ? w0 : w123);
  endtask

  task automatic load_centre();
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 9; k++)
        host_write(WBASE + o * 9 + k, (k == 4) ? 8'h10 : 8'h00);
  endtask

  task automatic check_conv(input string tag, input logic [7:0] e0, input logic [7:0] e123);
    logic [7:0] d;
    for (int o = 0; o < 4; o++)
      for (int p = 0; p < 36; p++) begin
        host_read(OBASE + o * 36 + p, d);
        check_eq($sformatf("%s_o%0d_p%0d", tag, o, p), 32'(d), 32'((o == 0) ? e0 : e123));
      end
  endtask

  // Start a run, flip relu/pool after the start edge, and count pulses over a fixed window.
  task automatic run_cnn(input logic rl, input logic mp, input bit mid,
                         output int nfin, output int nfil, output int npic, output int nmp);
    bit kicked;
    kicked = 1'b0;
    nfin = 0; nfil = 0; npic = 0; nmp = 0;
    @(negedge clk);
    relu = rl; maxpooling_or_not = mp; cnn_start = 1'b1;
    @(negedge clk);
    cnn_start = 1'b0; relu = ~rl; maxpooling_or_not = ~mp;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      cnn_start = 1'b0;
      if (cnn_finish) nfin++;
      if (filter_finish) nfil++;
      if (picture_finish) npic++;
      if (mp_picture_finish) nmp++;
      if (mid && !kicked && cnn_state == 8'd2) begin
        cnn_start = 1'b1;
        kicked = 1'b1;
      end
    end
    cnn_start = 1'b0;
  endtask

  initial begin
    int nf, nfl, np, nmp;
    logic [7:0] d;
    bit seen;

    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(cnn_state), 32'd0);
    check_eq("rst_finish", 32'(cnn_finish), 32'd0);
    check_eq("rst_wea", 32'(wea_w), 32'd0);
    rst = 1'b0;

    // 1.0 * 0.25 * 9 taps = 2.25
    load_inputs(0);
    load_weights(8'h04, 8'h04);
    run_cnn(1'b0, 1'b0, 1'b0, nf, nfl, np, nmp);
    check_eq("t1_finish_cnt", 32'(nf), 32'd1);
    check_eq("t1_filter_cnt", 32'(nfl), 32'd1);
    check_eq("t1_picture_cnt", 32'(np), 32'd1);
    check_eq("t1_mp_cnt", 32'(nmp), 32'd0);
    check_eq("t1_idle", 32'(cnn_state), 32'd0);
    check_conv("t1", 8'h24, 8'h24);

    // 1.0 * 2.0 * 9 = 18.0 saturates
    load_weights(8'h20, 8'h20);
    run_cnn(1'b0, 1'b0, 1'b0, nf, nfl, np, nmp);
    check_eq("t2_finish_cnt", 32'(nf), 32'd1);
    check_conv("t2", 8'h7F, 8'h7F);

    // filter 0 at -0.25 -> -2.25 = 0xDC, clamped to 0 under ReLU
    load_weights(8'hFC, 8'h04);
    run_cnn(1'b0, 1'b0, 1'b0, nf, nfl, np, nmp);
    check_eq("t3_finish_cnt", 32'(nf), 32'd1);
    check_conv("t3", 8'hDC, 8'h24);
    run_cnn(1'b1, 1'b0, 1'b0, nf, nfl, np, nmp);
    check_eq("t3r_finish_cnt", 32'(nf), 32'd1);
    check_conv("t3r", 8'h00, 8'h24);

    // second start while in MAC must be ignored
    run_cnn(1'b0, 1'b0, 1'b1, nf, nfl, np, nmp);
    check_eq("t4_finish_cnt", 32'(nf), 32'd1);
    check_eq("t4_filter_cnt", 32'(nfl), 32'd1);
    host_read(OBASE, d);
    check_eq("t4_readback_o0", 32'(d), 32'hDC);
    host_read(OBASE + 36, d);
    check_eq("t4_readback_o1", 32'(d), 32'h24);

    // asynchronous reset in the middle of MAC
    @(negedge clk);
    cnn_start = 1'b1;
    @(negedge clk);
    cnn_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (cnn_state == 8'd2) seen = 1'b1;
    end
    check_eq("t5_reach_mac", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t5_pre_state", 32'(cnn_state), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_state", 32'(cnn_state), 32'd0);
    check_eq("t5_rst_wea", 32'(wea_w), 32'd0);
    check_eq("t5_rst_finish", 32'(cnn_finish), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nf = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (cnn_finish) nf++;
    end
    check_eq("t5_no_finish", 32'(nf), 32'd0);
    check_eq("t5_idle", 32'(cnn_state), 32'd0);

`ifdef MAXPOOL_EN
    // conv(r,c) = (c+1)<<4, pooled(r,c) = (2c+2)<<4
    load_inputs(1);
    load_centre();
    run_cnn(1'b0, 1'b1, 1'b0, nf, nfl, np, nmp);
    check_eq("t6_finish_cnt", 32'(nf), 32'd1);
    check_eq("t6_mp_cnt", 32'(nmp), 32'd1);
    check_eq("t6_idle", 32'(cnn_state), 32'd0);
    host_read(OBASE + 5, d);
    check_eq("t6_conv_c5", 32'(d), 32'h60);
    for (int o = 0; o < 4; o++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          host_read(PBASE + o * 9 + r * 3 + c, d);
          check_eq($sformatf("t6_pool_o%0d_r%0d_c%0d", o, r, c), 32'(d), 32'((2 * c + 2) << 4));
        end
`else
    // pooling request is ignored: PBASE untouched, no pool pulse
    host_write(PBASE, 8'h5A);
    run_cnn(1'b0, 1'b1, 1'b0, nf, nfl, np, nmp);
    check_eq("t6_finish_cnt", 32'(nf), 32'd1);
    check_eq("t6_mp_cnt", 32'(nmp), 32'd0);
    host_read(PBASE, d);
    check_eq("t6_pbase_kept", 32'(d), 32'h5A);
    host_read(OBASE, d);
    check_eq("t6_conv_o0", 32'(d), 32'hDC);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/top_test.md
Name: top_test

Overview:
- Single-layer CNN engine: convolution over an on-chip byte memory using 4 parallel MAC PEs (one per output filter), optional ReLU, optional 2x2 max-pooling, results written back to the same memory.
- Started by a `cnn_start` pulse; signals completion with `cnn_finish`.
- A host port preloads and reads back the memory while the engine is idle.

Parameters:
- WIDTH, 8, data width; signed fixed point.
- DECIMAL, 4, fractional bits (Q4.4).
- MEMADDRBIT, 17, memory address width; depth 2^MEMADDRBIT bytes.
- DI, 1, input channels.
- DR, 8, input rows.
- DC, 8, input columns.
- DK, 3, square kernel size.
- WBASE, 1024, weight base address.
- OBASE, 2048, conv output base address.
- PBASE, 4096, pool output base address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cnn_start  in  1  start pulse.
- relu  in  1  apply ReLU to conv outputs; sampled at start.
- maxpooling_or_not  in  1  run pooling after conv; sampled at start.
- checkbram  in  1  host access enable; honoured only in IDLE.
- host_we  in  1  host write strobe; qualified by checkbram.
- host_wdata  in  WIDTH  host write data.
- memaddr_check  in  MEMADDRBIT  host address.
- memaddr  out  MEMADDRBIT  current memory address.
- mem_in  out  WIDTH  data being written to memory.
- mem_out  out  WIDTH  memory read data.
- wea_w  out  1  memory write enable.
- cnn_state  out  8  FSM state code.
- cnn_finish  out  1  done pulse.
- filter_finish  out  1  weight load done pulse.
- picture_finish  out  1  conv done pulse.
- mp_picture_finish  out  1  pool done pulse.

Behaviour:
- Fixed geometry:
  - DO = 4 filters; stride 1; no padding.
  - DRO = DR-DK+1, DCO = DC-DK+1.
  - Pool output is DRO/2 x DCO/2 (floor).
- Memory layout:
  - Input at ii*DR*DC + r*DC + c.
  - Weights at WBASE + ((o*DI+ii)*DK+kr)*DK+kc.
  - Conv output at OBASE + o*DRO*DCO + r*DCO + c.
  - Pool output at PBASE with the same layout on the pooled size.
- Memory is single-port: synchronous write, synchronous read with 1-cycle latency. Memory contents are not affected by rst.
- Reset: `cnn_state` = 0 (IDLE); all pulses, `wea_w`, counters and accumulators = 0.
- FSM states: 0 IDLE, 1 LOADW, 2 MAC, 3 WRITE, 4 POOL, 5 DONE.
- IDLE:
  - Drives `memaddr` = `memaddr_check`.
  - `checkbram` && `host_we` writes `host_wdata`.
  - `mem_out` is valid one cycle after the address.
  - `cnn_start` moves to LOADW and latches `relu` and `maxpooling_or_not`.
  - Host access is ignored outside IDLE.
- LOADW:
  - Reads 4*DI*DK*DK weights into internal per-PE registers, one read per cycle, plus 1 drain cycle.
  - Pulses `filter_finish` for 1 cycle, then enters MAC.
- MAC:
  - Per output pixel, reads DI*DK*DK input bytes in (ii,kr,kc) order.
  - Each byte is broadcast to the 4 PEs; each PE does acc += x*w[o].
  - Product is 16-bit signed; accumulator is 20-bit signed.
  - Phase takes DI*DK*DK+1 cycles, then WRITE.
- WRITE:
  - Result = acc >>> DECIMAL, saturated to [0x80, 0x7F].
  - If ReLU is latched, negative results become 0.
  - Writes PE0..PE3 on 4 consecutive cycles; `wea_w` is high for those cycles.
  - Accumulators clear; pixels advance c, then r.
  - After the last pixel, `picture_finish` pulses and the FSM goes to POOL if pooling is latched, else DONE.
- POOL:
  - For each (o, r, c): reads the 2x2 window from conv output (4 cycles), 1 drain cycle, 1 write of the signed max.
  - After the last output, `mp_picture_finish` pulses and the FSM goes to DONE.
- DONE: pulses `cnn_finish` for 1 cycle, then IDLE.
- `cnn_start` is ignored while not in IDLE.
- Reset mid-run aborts immediately to IDLE; partially written outputs remain in memory.

Optional Feature:
- MAXPOOL_EN defined: POOL state and `mp_picture_finish` are implemented.
- MAXPOOL_EN undefined:
  - POOL logic is absent.
  - `maxpooling_or_not` is ignored.
  - WRITE goes straight to DONE after the last pixel.
  - `mp_picture_finish` is tied to 0.

Test Plan:
- Reset -> `cnn_state`=0, `cnn_finish`=0, `wea_w`=0; assert rst mid-MAC -> `cnn_state`=0 within the same cycle, no `cnn_finish`.
- Preload inputs 0x10 and all weights 0x04, relu=0, no pool, start -> all 144 conv outputs = 0x24 (2.25); `cnn_finish` pulses once.
- All weights 0x20 (2.0) with inputs 0x10 -> outputs saturate to 0x7F.
- Filter 0 weights 0xFC -> filter-0 outputs 0xDC with relu=0, 0x00 with relu=1; filters 1-3 unaffected.
- MAXPOOL_EN, inputs = column index c in Q4.4 (c<<4), weights: only centre tap 0x10 -> pooled output at (r,c) = (2c+2)<<4, 3x3 per filter at PBASE.
- Pulse `cnn_start` during MAC -> ignored, single `cnn_finish`; afterwards `checkbram` readback of OBASE returns the written value one cycle after the address.
